keypad_event_fifo: RTL and testbench

KEYPAD_EVENT_FIFO -- requirements
Module: keypad_event_fifo

---
 rtl/keypad_event_fifo.sv | 133 +++++++++++++
 tb/tb_keypad_event_fifo.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_event_fifo.sv
// Keypad event queue: prioritised press/release/repeat events into a FIFO, head shown directly.
// Latency: a pulse is queued at the edge that samples it and becomes visible right after that edge.
// Backpressure: when the FIFO is full, events wait in pending bits; a second pulse for a waiting bit sets overflow.
module keypad_event_fifo #(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [23:0] REPEAT_DLY  = 24'd5_000_000,
    parameter logic [23:0] REPEAT_RATE = 24'd1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] key_down,
    input  logic [15:0] key_up,
    input  logic [15:0] key_state,
    input  logic        rd_en,
    output logic        evt_valid,
    output logic [5:0]  evt_data,
    output logic [4:0]  fifo_count,
    output logic        overflow,
    input  logic        ovf_clr
);

    localparam int          PW      = $clog2(FIFO_DEPTH);
    localparam logic [4:0]  DEPTH_L = 5'(FIFO_DEPTH);

    logic [15:0]   pend_press, pend_rel;
    logic          pend_rep, rep_active;
    logic [3:0]    rep_key;
    logic [23:0]   rep_cnt;
    logic [5:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [4:0]    count;

    logic [15:0] eff_press, eff_rel, clr_press, clr_rel;
    logic        press_found, rel_found;
    logic [3:0]  press_idx, rel_idx;
    logic        rep_hold, rep_tick, eff_rep;
    logic        sel_vld, push, pop, full;
    logic [5:0]  sel_dat;
    logic        press_acc, rel_acc, rep_acc, rep_stop, ovf_set;

    // Same-cycle pulses and repeat ticks bypass the pending bits so they can be queued immediately.
    always_comb begin
        eff_press   = pend_press | key_down;
        eff_rel     = pend_rel | key_up;
        rep_hold    = rep_active & key_state[rep_key];
        rep_tick    = rep_hold & (rep_cnt <= 24'd1);
        eff_rep     = pend_rep | rep_tick;
        press_found = 1'b0;
        rel_found   = 1'b0;
        press_idx   = 4'd0;
        rel_idx     = 4'd0;
        for (int k = 15; k >= 0; k--) begin
            if (eff_press[k]) begin
                press_found = 1'b1;
                press_idx   = 4'(k);
            end
            if (eff_rel[k]) begin
                rel_found = 1'b1;
                rel_idx   = 4'(k);
            end
        end
        sel_vld = press_found | rel_found | eff_rep;
        if (press_found)    sel_dat = {2'b01, press_idx};
        else if (rel_found) sel_dat = {2'b10, rel_idx};
        else                sel_dat = {2'b11, rep_key};
        pop       = rd_en & (count != 5'd0);
        full      = (count == DEPTH_L);
        push      = sel_vld & (~full | pop);
        press_acc = push & press_found;
        rel_acc   = push & ~press_found & rel_found;
        rep_acc   = push & ~press_found & ~rel_found & eff_rep;
        clr_press = press_acc ? (16'd1 << press_idx) : 16'd0;
        clr_rel   = rel_acc   ? (16'd1 << rel_idx)   : 16'd0;
        rep_stop  = rep_active & (~key_state[rep_key] | (rel_acc & (rel_idx == rep_key)));
        ovf_set   = (|(key_down & pend_press & ~clr_press)) | (|(key_up & pend_rel & ~clr_rel));
    end

    // A new pulse survives a same-cycle clear of an older pending event for the same key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_press <= '0;
            pend_rel   <= '0;
            overflow   <= 1'b0;
        end else begin
            pend_press <= (pend_press & ~clr_press) | (key_down & ~(clr_press & ~pend_press));
            pend_rel   <= (pend_rel & ~clr_rel) | (key_up & ~(clr_rel & ~pend_rel));
            if (ovf_set)      overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_active <= 1'b0;
            rep_key    <= 4'd0;
            rep_cnt    <= 24'd0;
            pend_rep   <= 1'b0;
        end else if (press_acc) begin
            rep_active <= 1'b1;
            rep_key    <= press_idx;
            rep_cnt    <= REPEAT_DLY;
            pend_rep   <= 1'b0;
        end else if (rep_stop) begin
            rep_active <= 1'b0;
            pend_rep   <= 1'b0;
        end else begin
            // A tick arriving while a repeat is still waiting merges into it.
            pend_rep <= eff_rep & ~rep_acc;
            if (rep_hold) rep_cnt <= rep_tick ? REPEAT_RATE : rep_cnt - 24'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 5'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {4'd0, push} - {4'd0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= sel_dat;
    end

    assign evt_valid  = (count != 5'd0);
    assign evt_data   = evt_valid ? mem[rd_ptr] : 6'd0;
    assign fifo_count = count;

endmodule

// File: tb/tb_keypad_event_fifo.sv
// Bench for keypad_event_fifo: scenario tasks with a queue of expected events.
module tb_keypad_event_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] key_down = '0;
    logic [15:0] key_up = '0;
    logic [15:0] key_state = '0;
    logic        rd_en = 1'b0;
    logic        ovf_clr = 1'b0;
    logic        evt_valid;
    logic [5:0]  evt_data;
    logic [4:0]  fifo_count;
    logic        overflow;

    int total = 0;
    int bad = 0;
    logic [5:0] exp_q [$];

    keypad_event_fifo #(
        .FIFO_DEPTH (8),
        .REPEAT_DLY (24'd10),
        .REPEAT_RATE(24'd4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_down  (key_down),
        .key_up    (key_up),
        .key_state (key_state),
        .rd_en     (rd_en),
        .evt_valid (evt_valid),
        .evt_data  (evt_data),
        .fifo_count(fifo_count),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        exp_q.delete();
    endtask

    // Pop every queued entry, comparing each head against the scoreboard.
    task automatic drain(input string name);
        logic [5:0] exp;
        for (int i = 0; i < 40 && evt_valid; i++) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL %s_extra: got %h, expected nothing", name, evt_data);
            end else begin
                exp = exp_q.pop_front();
                if (evt_data !== exp) begin
                    bad++;
                    $display("FAIL %s_data: got %h, expected %h", name, evt_data, exp);
                end
            end
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
        end
        total++;
        if (evt_valid !== 1'b0 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_end: valid=%b left=%0d, expected valid=0 left=0", name, evt_valid, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        total++;
        if ({evt_valid, fifo_count, evt_data, overflow} !== 13'd0) begin
            bad++;
            $display("FAIL reset: valid=%b cnt=%0d data=%h ovf=%b, expected all 0", evt_valid, fifo_count, evt_data, overflow);
        end
        do_reset();
    endtask

    task automatic test_single;
        key_down = 16'h0020;
        exp_q.push_back(6'h15);
        tick();
        key_down = '0;
        total++;
        if (evt_valid !== 1'b1 || evt_data !== 6'h15 || fifo_count !== 5'd1) begin
            bad++;
            $display("FAIL single: valid=%b data=%h cnt=%0d, expected 1 15 1", evt_valid, evt_data, fifo_count);
        end
        drain("single");
    endtask

    task automatic test_same_cycle;
        key_down = 16'h0208;
        exp_q.push_back(6'h13);
        exp_q.push_back(6'h19);
        tick();
        key_down = '0;
        total++;
        if (fifo_count !== 5'd1) begin
            bad++;
            $display("FAIL same_first: cnt=%0d, expected 1", fifo_count);
        end
        tick();
        total++;
        if (fifo_count !== 5'd2 || evt_data !== 6'h13) begin
            bad++;
            $display("FAIL same_second: cnt=%0d data=%h, expected 2 13", fifo_count, evt_data);
        end
        drain("same");
    endtask

    task automatic test_full;
        logic [5:0] exp;
        for (int i = 0; i < 9; i++) begin
            key_down = 16'd1 << i;
            exp_q.push_back({2'b01, 4'(i)});
            tick();
        end
        key_down = '0;
        tick();
        total++;
        if (fifo_count !== 5'd8 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL full: cnt=%0d ovf=%b, expected 8 0", fifo_count, overflow);
        end
        exp = exp_q.pop_front();
        total++;
        if (evt_data !== exp) begin
            bad++;
            $display("FAIL full_head: got %h, expected %h", evt_data, exp);
        end
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        total++;
        if (fifo_count !== 5'd8) begin
            bad++;
            $display("FAIL full_refill: cnt=%0d, expected 8", fifo_count);
        end
        drain("full");
    endtask

    task automatic test_overflow;
        int keys [8] = '{0, 1, 3, 4, 5, 6, 7, 8};
        foreach (keys[i]) begin
            key_down = 16'd1 << keys[i];
            exp_q.push_back({2'b01, 4'(keys[i])});
            tick();
        end
        key_down = 16'h0004;
        exp_q.push_back(6'h12);
        tick();
        key_down = '0;
        total++;
        if (fifo_count !== 5'd8 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_pending: cnt=%0d ovf=%b, expected 8 0", fifo_count, overflow);
        end
        key_down = 16'h0004;
        tick();
        key_down = '0;
        tick();
        total++;
        if (overflow !== 1'b1) begin
            bad++;
            $display("FAIL ovf_set: ovf=%b, expected 1", overflow);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        total++;
        if (overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clr: ovf=%b, expected 0", overflow);
        end
        drain("ovf");
    endtask

    task automatic test_repeat;
        int exp_cnt = 1;
        key_state = 16'h0080;
        key_down  = 16'h0080;
        exp_q.push_back(6'h17);
        tick();
        key_down = '0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (c >= 10 && (c - 10) % 4 == 0) begin
                exp_q.push_back(6'h37);
                exp_cnt++;
            end
            total++;
            if (fifo_count !== 5'(exp_cnt)) begin
                bad++;
                $display("FAIL repeat_cnt c=%0d: cnt=%0d, expected %0d", c, fifo_count, exp_cnt);
            end
        end
        key_up    = 16'h0080;
        key_state = '0;
        exp_q.push_back(6'h27);
        tick();
        key_up = '0;
        for (int c = 0; c < 20; c++) tick();
        total++;
        if (fifo_count !== 5'd8) begin
            bad++;
            $display("FAIL repeat_stop: cnt=%0d, expected 8", fifo_count);
        end
        drain("repeat");
    endtask

    task automatic test_reset_mid;
        key_down = 16'h0002; tick();
        key_down = 16'h0004; tick();
        key_down = 16'h0008; tick();
        key_down = '0;
        total++;
        if (fifo_count !== 5'd3) begin
            bad++;
            $display("FAIL rmid_fill: cnt=%0d, expected 3", fifo_count);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (evt_valid !== 1'b0 || fifo_count !== 5'd0) begin
            bad++;
            $display("FAIL rmid_now: valid=%b cnt=%0d, expected 0 0", evt_valid, fifo_count);
        end
        key_down = 16'h0100;
        tick();
        key_down = '0;
        rst_n = 1'b1;
        tick();
        tick();
        total++;
        if (evt_valid !== 1'b0 || fifo_count !== 5'd0) begin
            bad++;
            $display("FAIL rmid_after: valid=%b cnt=%0d, expected 0 0", evt_valid, fifo_count);
        end
        exp_q.delete();
        key_down = 16'h0010;
        exp_q.push_back(6'h14);
        tick();
        key_down = '0;
        total++;
        if (fifo_count !== 5'd1) begin
            bad++;
            $display("FAIL rmid_fresh: cnt=%0d, expected 1", fifo_count);
        end
        drain("rmid");
    endtask

    initial begin
        test_reset();
        test_single();
        test_same_cycle();
        do_reset();
        test_full();
        do_reset();
        test_overflow();
        do_reset();
        test_repeat();
        do_reset();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
